// File: rtl/comp_seq_ctrl_if.sv
// Request/result handshake bundle for the serial magnitude-compare sequencer.
// The master drives operands and consumes verdicts; the slave is the sequencer.
interface comp_seq_ctrl_if #(
   parameter int unsigned WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic             eq;
   logic             gr;
   logic             le;
   logic             busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, eq, gr, le, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, eq, gr, le, busy
   );
endinterface

// File: rtl/comp_seq_ctrl.sv
// Serial magnitude comparator: one shared 2-bit eq/gr/le slice walks the operands
// MSB pair first, optionally stopping at the first unequal pair.
module comp_seq_ctrl #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_EXIT = 1'b1
) (
   input logic             clk,
   input logic             rst,
   comp_seq_ctrl_if.slave  bus
);
   localparam int unsigned PAIRS = WIDTH / 2;
   localparam int unsigned IW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [IW-1:0]    idx;
   logic             decided;
   logic             eq_r;
   logic             gr_r;
   logic             le_r;
   logic [1:0]       pa;
   logic [1:0]       pb;
   logic             slice_gr;
   logic             slice_le;

   always_comb begin
      pa       = a_r[{idx, 1'b0} +: 2];
      pb       = b_r[{idx, 1'b0} +: 2];
      slice_gr = (pa[1] & ~pb[1]) | ((pa[1] ~^ pb[1]) & pa[0] & ~pb[0]);
      slice_le = (~pa[1] & pb[1]) | ((pa[1] ~^ pb[1]) & ~pa[0] & pb[0]);
   end

   assign bus.in_ready  = (state == IDLE) && !rst;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.eq        = eq_r;
   assign bus.gr        = gr_r;
   assign bus.le        = le_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         a_r     <= '0;
         b_r     <= '0;
         idx     <= '0;
         decided <= 1'b0;
         eq_r    <= 1'b0;
         gr_r    <= 1'b0;
         le_r    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_r     <= bus.a;
                  b_r     <= bus.b;
                  idx     <= IW'(PAIRS - 1);
                  decided <= 1'b0;
                  state   <= SCAN;
               end
            end
            SCAN: begin
               if (!decided && (slice_gr || slice_le)) begin
                  gr_r    <= slice_gr;
                  le_r    <= slice_le;
                  decided <= 1'b1;
                  if (EARLY_EXIT) state <= DONE;
               end
               // eq only when no pair, including this last one, differed
               if (idx == '0) begin
                  state <= DONE;
                  if (!decided && !slice_gr && !slice_le) eq_r <= 1'b1;
               end else begin
                  idx <= idx - 1'b1;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state <= IDLE;
                  eq_r  <= 1'b0;
                  gr_r  <= 1'b0;
                  le_r  <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
